imem_loader: RTL and testbench

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, parses a length header, assembles big-endian 32-bit instruction words and writes them to consecutive word-aligned addresses. It then validates a trailing XOR checksum.

While loading, it holds the processor in reset. It releases the processor only after a successful load.

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Stream source / memory side (e.g. boot ROM reader and memory wrapper).
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a 16-bit word-count header,
// assembles big-endian words, writes them to consecutive word addresses and
// validates a trailing XOR checksum. Holds the CPU until a good load.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | expecting word-count high byte
// LEN_LO  | expecting word-count low byte, range-checked on arrival
// DATA    | accepting instruction bytes, one write per 4 bytes
// CHECK   | expecting checksum byte
// DONE    | load good, CPU released (sticky until start/reset)
// ERROR   | overflow or bad checksum, CPU held (sticky until start/reset)
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // 17 bits so that 2^ADDR_WIDTH is representable even at ADDR_WIDTH=16.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  csum_q, csum_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        ready;
  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] word_idx_inc;

  // Ready is a pure decode of registered state, so it never depends on valid.
  assign ready        = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer         = bus.byte_valid && ready;
  assign len_full     = {len_q[15:8], bus.byte_in};
  assign word_idx_inc = word_idx_q + 16'd1;

  assign bus.byte_ready = ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign error          = error_q;

  // Next-state and datapath updates; mem_we is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          done_d     = 1'b0;
          error_d    = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          cpu_hold_d = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.byte_in;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d    = {shift_q[15:0], bus.byte_in};
          csum_d     = csum_q ^ bus.byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = 32'({word_idx_q, 2'b00});
            mem_wdata_d = {shift_q, bus.byte_in};
            word_idx_d  = word_idx_inc;
            if (word_idx_inc == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (bus.byte_in == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset overrides start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-position model checked every cycle, plus
// hand-computed literal expectations per scenario.
module tb_imem_loader;
  localparam int AW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tracks position within the stream since the last start.
  bit          chk_en = 1'b0;
  bit          m_act  = 1'b0;
  int          m_pos, m_n;
  logic [7:0]  m_hi, m_csum;
  logic [31:0] m_word;
  logic        e_we = 1'b0, e_hold = 1'b1, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;

  always @(posedge clock) begin
    int p;
    if (reset) begin
      m_act = 0; m_pos = 0; m_csum = '0; m_word = '0;
      e_we = 0; e_addr = '0; e_wdata = '0; e_hold = 1; e_done = 0; e_err = 0;
      chk_en = 1'b1;
    end else begin
      e_we = 0;
      if (m_act) begin
        if (bus.byte_valid) begin
          p = m_pos;
          m_pos++;
          if (p == 0) m_hi = bus.byte_in;
          else if (p == 1) begin
            m_n = {m_hi, bus.byte_in};
            if (m_n > (1 << AW)) begin m_act = 0; e_err = 1; end
          end else if (p < 2 + 4 * m_n) begin
            m_word = {m_word[23:0], bus.byte_in};
            m_csum = m_csum ^ bus.byte_in;
            if ((p - 2) % 4 == 3) begin
              e_we = 1; e_addr = 32'((p - 2) / 4 * 4); e_wdata = m_word;
            end
          end else begin
            m_act = 0;
            if (bus.byte_in == m_csum) begin e_done = 1; e_hold = 0; end
            else e_err = 1;
          end
        end
      end else if (start) begin
        m_act = 1; m_pos = 0; m_csum = '0;
        e_done = 0; e_err = 0; e_hold = 1;
      end
    end
  end

  // Per-cycle compare, and a log of observed writes for literal checks.
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];

  always @(negedge clock) begin
    if (chk_en) begin
      chk("byte_ready", 32'(bus.byte_ready), 32'(m_act));
      chk("mem_we",     32'(bus.mem_we),     32'(e_we));
      chk("mem_addr",   bus.mem_addr,        e_addr);
      chk("mem_wdata",  bus.mem_wdata,       e_wdata);
      chk("cpu_hold",   32'(cpu_hold),       32'(e_hold));
      chk("done",       32'(done),           32'(e_done));
      chk("error",      32'(error),          32'(e_err));
      if (bus.mem_we === 1'b1) begin
        wlog_a.push_back(bus.mem_addr);
        wlog_d.push_back(bus.mem_wdata);
      end
    end
  end

  // Stimulus helpers; all start and end at a falling edge.
  logic [7:0]  sq[$];
  logic [31:0] words[$];

  task automatic build_stream(input bit bad);
    logic [7:0] cs;
    logic [15:0] n;
    cs = '0;
    n = 16'(words.size());
    sq = {};
    sq.push_back(n[15:8]);
    sq.push_back(n[7:0]);
    foreach (words[i]) begin
      for (int b = 3; b >= 0; b--) begin
        sq.push_back(words[i][b*8 +: 8]);
        cs = cs ^ words[i][b*8 +: 8];
      end
    end
    sq.push_back(bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic send_bytes(input int max_gap, input int count);
    int lim;
    lim = (count < 0) ? sq.size() : count;
    for (int i = 0; i < lim; i++) begin
      int g;
      int t;
      bit got;
      bit rdy;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) @(negedge clock);
      bus.byte_in    = sq[i];
      bus.byte_valid = 1'b1;
      got = 0; t = 0;
      while (!got && t < 50) begin
        rdy = bus.byte_ready;
        @(posedge clock);
        got = rdy;
        t++;
        @(negedge clock);
      end
      bus.byte_valid = 1'b0;
      if (!got) begin
        n_checks++; n_fail++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted within 50 cycles", i);
        return;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wlog_a = {};
    wlog_d = {};
  endtask

  initial begin
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);

    // Single word, literal stream.
    clear_log();
    do_start();
    sq = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    send_bytes(0, -1);
    chk("s1_nwrites", 32'(wlog_a.size()), 32'd1);
    if (wlog_a.size() > 0) begin
      chk("s1_addr", wlog_a[0], 32'h0);
      chk("s1_data", wlog_d[0], 32'h20080005);
    end
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_hold", 32'(cpu_hold), 32'd0);
    chk("s1_error", 32'(error), 32'd0);

    // Three words back-to-back, then with stalls.
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      words = {32'h11223344, 32'hAABBCCDD, 32'h01020304};
      build_stream(0);
      chk("s2_csum_pin", 32'(sq[sq.size()-1]), 32'h40);
      do_start();
      send_bytes(pass == 0 ? 0 : 5, -1);
      chk("s2_nwrites", 32'(wlog_a.size()), 32'd3);
      if (wlog_a.size() == 3) begin
        chk("s2_addr2", wlog_a[2], 32'h8);
        chk("s2_data1", wlog_d[1], 32'hAABBCCDD);
      end
      chk("s2_done", 32'(done), 32'd1);
    end

    // Bad checksum, then recovery.
    clear_log();
    do_start();
    sq = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    send_bytes(0, -1);
    chk("s4_nwrites", 32'(wlog_a.size()), 32'd1);
    chk("s4_error", 32'(error), 32'd1);
    chk("s4_done", 32'(done), 32'd0);
    chk("s4_hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(negedge clock);
    chk("s4_sticky", 32'(error), 32'd1);
    do_start();
    sq = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    send_bytes(0, -1);
    chk("s4_recover_done", 32'(done), 32'd1);

    // N = 257: overflow after header.
    clear_log();
    do_start();
    sq = {8'h01, 8'h01};
    send_bytes(0, -1);
    chk("s5_error", 32'(error), 32'd1);
    chk("s5_ready", 32'(bus.byte_ready), 32'd0);
    repeat (4) @(negedge clock);
    chk("s5_nwrites", 32'(wlog_a.size()), 32'd0);

    // N = 256: full memory.
    clear_log();
    words = {};
    for (int i = 0; i < 256; i++) words.push_back($urandom());
    build_stream(0);
    do_start();
    send_bytes(0, -1);
    chk("s6_nwrites", 32'(wlog_a.size()), 32'd256);
    if (wlog_a.size() > 0) chk("s6_last_addr", wlog_a[wlog_a.size()-1], 32'h3FC);
    chk("s6_done", 32'(done), 32'd1);

    // N = 0.
    clear_log();
    do_start();
    sq = {8'h00, 8'h00, 8'h00};
    send_bytes(0, -1);
    chk("s7_done", 32'(done), 32'd1);
    chk("s7_nwrites", 32'(wlog_a.size()), 32'd0);

    // Reset after the 6th data byte; stray start mid-load; reset beats start.
    clear_log();
    words = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678};
    build_stream(0);
    do_start();
    send_bytes(0, 8);
    do_start();
    chk("s8_start_ignored", 32'(bus.byte_ready), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("s8_rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("s8_rst_we", 32'(bus.mem_we), 32'd0);
    chk("s8_rst_addr", bus.mem_addr, 32'd0);
    chk("s8_rst_wdata", bus.mem_wdata, 32'd0);
    chk("s8_rst_hold", 32'(cpu_hold), 32'd1);
    chk("s8_nwrites", 32'(wlog_a.size()), 32'd1);
    if (wlog_d.size() > 0) chk("s8_word0", wlog_d[0], 32'hDEADBEEF);
    clear_log();
    do_start();
    send_bytes(2, -1);
    chk("s8_nwrites_full", 32'(wlog_a.size()), 32'd3);
    chk("s8_done", 32'(done), 32'd1);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
